// File: rtl/sqr_seq.sv
// Sequential unsigned squarer: shift-and-add over N cycles using an external
// shared summator (aw + bw -> sum_res), one operand bit per cycle.
module sqr_seq #(
    parameter int N = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [N-1:0]   a_bi,
    output logic           ready,
    output logic           busy_o,
    output logic [2*N-1:0] y_bo,
    output logic [2*N:0]   aw,
    output logic [2*N:0]   bw,
    input  logic [2*N:0]   sum_res
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    // Handshake: start_i is taken only on a rising edge where ready=1; a
    // result is valid in y_bo from the edge where busy_o falls until the next one.
    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]   op_q;
    logic [2*N-1:0] acc_q;
    logic [2*N-1:0] y_q;
    logic [CW-1:0]  cnt_q;

    logic load;
    logic step;
    logic last;

    logic [2*N:0] op_ext;

    // The summator carry-out can never be set for a valid square, so it is dropped.
    logic sum_msb_unused;
    assign sum_msb_unused = sum_res[2*N];

    assign op_ext = {{(N + 1){1'b0}}, op_q};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        ready      = 1'b0;
        busy_o     = 1'b0;
        aw         = '0;
        bw         = '0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start_i) begin
                    load       = 1'b1;
                    state_next = WORK;
                end
            end
            WORK: begin
                busy_o = 1'b1;
                step   = 1'b1;
                aw     = {1'b0, acc_q};
                if (op_q[cnt_q]) begin
                    bw = op_ext << cnt_q;
                end
                if (cnt_q == CNT_LAST) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            op_q  <= a_bi;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (step) begin
            acc_q <= sum_res[2*N-1:0];
            cnt_q <= last ? '0 : cnt_q + CW'(1);
        end
    end

    // Result register only moves on the final iteration, so it stays stable during WORK.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            y_q <= '0;
        end else if (last) begin
            y_q <= sum_res[2*N-1:0];
        end
    end

    assign y_bo = y_q;

endmodule

// File: tb/tb_sqr_seq.sv
// Bench for sqr_seq: external summator, arithmetic reference model and a
// scoreboard queue of expected squares checked when the model says a result lands.
module tb_sqr_seq;

    localparam int N = 8;

    logic           clk_i   = 1'b0;
    logic           rst_i   = 1'b0;
    logic           start_i = 1'b0;
    logic [N-1:0]   a_bi    = '0;
    logic           ready;
    logic           busy_o;
    logic [2*N-1:0] y_bo;
    logic [2*N:0]   aw;
    logic [2*N:0]   bw;
    logic [2*N:0]   sum_res;

    sqr_seq #(.N(N)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_bi    (a_bi),
        .ready   (ready),
        .busy_o  (busy_o),
        .y_bo    (y_bo),
        .aw      (aw),
        .bw      (bw),
        .sum_res (sum_res)
    );

    // clock / reset block
    always #5 clk_i = ~clk_i;

    // external summator
    assign sum_res = aw + bw;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
    endtask

    // reference model: an accepted request occupies exactly N cycles
    logic [2*N-1:0]  exp_q[$];
    bit              m_busy    = 1'b0;
    int              m_i       = 0;
    longint unsigned m_a       = 0;
    logic [2*N-1:0]  m_y       = '0;
    bit              m_done    = 1'b0;
    int              m_accepts = 0;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_busy = 1'b0;
            m_i    = 0;
            m_y    = '0;
            m_done = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_i++;
                if (m_i == N) begin
                    m_busy = 1'b0;
                    m_y    = (2*N)'(m_a * m_a);
                    m_done = 1'b1;
                end
            end else if (start_i) begin
                m_busy = 1'b1;
                m_a    = longint'(a_bi);
                m_i    = 0;
                exp_q.push_back((2*N)'(longint'(a_bi) * longint'(a_bi)));
                m_accepts++;
            end
        end
    end

    // monitor / scoreboard
    bit prev_busy = 1'b0;
    int busy_rise_cyc[$];

    always @(negedge clk_i) begin
        longint unsigned lo_now, lo_next, bw_exp;
        logic [2*N-1:0] got;
        check("busy", busy_o, m_busy);
        check("ready", ready, !m_busy);
        check("y_hold", y_bo, m_y);
        if (m_busy) begin
            lo_now  = m_a % (64'd1 << m_i);
            lo_next = m_a % (64'd1 << (m_i + 1));
            bw_exp  = ((m_a >> m_i) & 64'd1) != 0 ? (m_a << m_i) : 64'd0;
            check("aw_work", aw, m_a * lo_now);
            check("bw_work", bw, bw_exp);
            check("sum_work", sum_res, m_a * lo_next);
        end else begin
            check("aw_idle", aw, 64'd0);
            check("bw_idle", bw, 64'd0);
        end
        if (m_done) begin
            if (exp_q.size() == 0) begin
                timeout("result_without_request");
            end else begin
                got = y_bo;
                check("result", got, exp_q.pop_front());
            end
        end
        if (!prev_busy && busy_o) busy_rise_cyc.push_back(cyc);
        prev_busy = busy_o;
    end

    // driver tasks
    task automatic wait_idle();
        int k = 0;
        while (m_busy && k < 40) begin
            @(negedge clk_i);
            k++;
        end
        if (m_busy) timeout("wait_idle");
    endtask

    task automatic issue(input logic [N-1:0] v);
        wait_idle();
        @(negedge clk_i);
        #1;
        start_i = 1'b1;
        a_bi    = v;
        @(negedge clk_i);
        #1;
        start_i = 1'b0;
        a_bi    = N'($urandom);
    endtask

    task automatic back_to_back();
        logic [N-1:0] vals[3];
        int base;
        int k;
        vals[0] = 8'd1;
        vals[1] = 8'd2;
        vals[2] = 8'd25;
        wait_idle();
        busy_rise_cyc.delete();
        @(negedge clk_i);
        #1;
        base    = m_accepts;
        start_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_bi = vals[i];
            k    = 0;
            while (m_accepts <= base + i && k < 20) begin
                @(negedge clk_i);
                k++;
            end
            if (m_accepts <= base + i) timeout("b2b_accept");
            #1;
        end
        start_i = 1'b0;
        wait_idle();
        @(negedge clk_i);
        check("b2b_starts", busy_rise_cyc.size(), 3);
        for (int i = 1; i < busy_rise_cyc.size(); i++) begin
            check("b2b_spacing", busy_rise_cyc[i] - busy_rise_cyc[i-1], N + 1);
        end
    endtask

    initial begin
        #3;
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_y", y_bo, 64'd0);
        check("rst_aw", aw, 64'd0);
        check("rst_bw", bw, 64'd0);
        start_i = 1'b1;
        a_bi    = 8'd77;
        repeat (2) @(negedge clk_i);
        #1;
        start_i = 1'b0;
        rst_i   = 1'b1;

        issue(8'd0);
        issue(8'd5);
        issue(8'd16);
        issue(8'd255);
        wait_idle();
        @(negedge clk_i);
        check("max_square", y_bo, 64'hFE01);

        // start raised mid-WORK must be ignored
        issue(8'd9);
        repeat (2) @(negedge clk_i);
        #1;
        start_i = 1'b1;
        a_bi    = 8'd3;
        @(negedge clk_i);
        #1;
        start_i = 1'b0;
        wait_idle();
        @(negedge clk_i);
        check("ignored_restart", y_bo, 64'd81);

        // reset during WORK, start held through reset
        issue(8'd200);
        repeat (3) @(negedge clk_i);
        #1;
        rst_i   = 1'b0;
        start_i = 1'b1;
        a_bi    = 8'd2;
        #1;
        check("abort_busy", busy_o, 1'b0);
        check("abort_ready", ready, 1'b1);
        check("abort_y", y_bo, 64'd0);
        check("abort_aw", aw, 64'd0);
        check("abort_bw", bw, 64'd0);
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("start_after_rst", busy_o, 1'b1);
        #1;
        start_i = 1'b0;
        wait_idle();
        @(negedge clk_i);
        check("post_rst_result", y_bo, 64'd4);

        back_to_back();
        check("b2b_last", y_bo, 64'd625);

        for (int i = 0; i < 20; i++) begin
            issue(N'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
        wait_idle();
        repeat (2) @(negedge clk_i);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
